// File: rtl/output_process_spi_if.sv
// output_process_spi_if: groups the header handshake, FIFO read port and serial
// output of output_process_spi. The master modport is the system/bench side and
// the slave modport is the transmitter.
interface output_process_spi_if;
    logic        TX_EN;
    logic        MSG_VALID;
    logic [15:0] MSG_CODE;
    logic [7:0]  MSG_LEN;
    logic        MSG_ACK;
    logic [15:0] SRC_DATA;
    logic        SRC_EMPTY;
    logic        SRC_RDREQ;
    logic        TX_DATA;
    logic        TX_LOAD;
    logic        TX_STOP;
    logic        TX_BUSY;
    logic        UNDERRUN;
    logic [2:0]  state_monitor;

    modport master (
        output TX_EN, MSG_VALID, MSG_CODE, MSG_LEN, SRC_DATA, SRC_EMPTY,
        input  MSG_ACK, SRC_RDREQ, TX_DATA, TX_LOAD, TX_STOP, TX_BUSY, UNDERRUN,
               state_monitor
    );

    modport slave (
        input  TX_EN, MSG_VALID, MSG_CODE, MSG_LEN, SRC_DATA, SRC_EMPTY,
        output MSG_ACK, SRC_RDREQ, TX_DATA, TX_LOAD, TX_STOP, TX_BUSY, UNDERRUN,
               state_monitor
    );
endinterface

// File: rtl/output_process_spi.sv
// output_process_spi: builds a serial frame (prefix, code, optional length,
// data words from a show-ahead FIFO, optional checksum) and shifts it out MSB
// first on RX_CLK, followed by GAP_WORDS idle word slots.
// Optional feature: define OUT_SPI_FRAME_CNT_EN to add the FRAME_CNT output,
// an 8-bit wrapping count of accepted headers.
//
// state  | meaning
// IDLE   | waiting for MSG_VALID, TX_DATA at idle level
// PREFIX | shifting the frame start word
// CODE   | shifting the latched code word
// LEN    | shifting {8'h00, length}
// DATA   | shifting FIFO words (zero filler when the FIFO is empty)
// CHKSUM | shifting the running 16-bit sum
// GAP    | idle word slots after the frame, still busy
module output_process_spi #(
    parameter logic [15:0] PREFIX     = 16'h55AA,
    parameter logic [15:0] EXIT_CODE  = 16'hFF00,
    parameter logic        IDLE_LEVEL = 1'b0,
    parameter int          GAP_WORDS  = 1
) (
    input  logic                 RX_CLK,
    input  logic                 RST,
`ifdef OUT_SPI_FRAME_CNT_EN
    output logic [7:0]           FRAME_CNT,
`endif
    output_process_spi_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREFIX_S = 3'd1,
        CODE   = 3'd2,
        LEN    = 3'd3,
        DATA   = 3'd4,
        CHKSUM = 3'd5,
        GAP    = 3'd6
    } state_t;

    localparam logic [15:0] IDLE_WORD = {16{IDLE_LEVEL}};
    localparam logic [7:0]  GAP_LAST  = 8'(GAP_WORDS - 1);

    state_t      state;
    state_t      nxt_frame;
    logic [15:0] shreg;
    logic [15:0] code_r;
    logic [15:0] chk;
    logic [15:0] src_word;
    logic [7:0]  len_r;
    logic [7:0]  word_cnt;
    logic [3:0]  bit_cnt;
    logic        msg_ack;
    logic        rdreq;
    logic        underrun;
    logic        busy;
    logic        accept;
    logic        last_data;
    logic        tx_load;

    assign accept    = (state == IDLE) && bus.MSG_VALID;
    assign src_word  = bus.SRC_EMPTY ? 16'h0000 : bus.SRC_DATA;
    assign last_data = (word_cnt == len_r - 8'd1);

    // Word that follows the current one once its LSB has been shifted out
    always_comb begin
        nxt_frame = GAP;
        case (state)
            PREFIX_S: nxt_frame = CODE;
            CODE: begin
                if (code_r == EXIT_CODE) nxt_frame = GAP;
                else if (code_r[0])      nxt_frame = LEN;
                else if (len_r != 8'd0)  nxt_frame = DATA;
                else if (code_r[1])      nxt_frame = CHKSUM;
            end
            LEN: begin
                if (len_r != 8'd0)       nxt_frame = DATA;
                else if (code_r[1])      nxt_frame = CHKSUM;
            end
            DATA: begin
                if (!last_data)          nxt_frame = DATA;
                else if (code_r[1])      nxt_frame = CHKSUM;
            end
            default:                     nxt_frame = GAP;
        endcase
    end

    // Frame sequencer: header accept, bit shifting, word loading and gap timing
    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST) begin
            state    <= IDLE;
            shreg    <= IDLE_WORD;
            code_r   <= 16'h0000;
            chk      <= 16'h0000;
            len_r    <= 8'h00;
            word_cnt <= 8'h00;
            bit_cnt  <= 4'd0;
            msg_ack  <= 1'b0;
            rdreq    <= 1'b0;
            underrun <= 1'b0;
            busy     <= 1'b0;
        end else begin
            msg_ack <= 1'b0;
            rdreq   <= 1'b0;
            if (state == IDLE) begin
                if (accept) begin
                    code_r   <= bus.MSG_CODE;
                    len_r    <= bus.MSG_LEN;
                    msg_ack  <= 1'b1;
                    busy     <= 1'b1;
                    shreg    <= PREFIX;
                    bit_cnt  <= 4'd15;
                    word_cnt <= 8'h00;
                    chk      <= 16'h0000;
                    state    <= PREFIX_S;
                end
            end else if (bus.TX_EN) begin
                if (bit_cnt != 4'd0) begin
                    shreg   <= {shreg[14:0], IDLE_LEVEL};
                    bit_cnt <= bit_cnt - 4'd1;
                end else begin
                    bit_cnt <= 4'd15;
                    if (state == GAP) begin
                        shreg <= IDLE_WORD;
                        if (word_cnt == GAP_LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + 8'd1;
                        end
                    end else begin
                        state <= nxt_frame;
                        case (nxt_frame)
                            CODE: begin
                                shreg <= code_r;
                                chk   <= code_r;
                            end
                            LEN: begin
                                shreg <= {8'h00, len_r};
                                chk   <= chk + {8'h00, len_r};
                            end
                            DATA: begin
                                // Filler still counts as a word so the frame length is kept
                                shreg    <= src_word;
                                chk      <= chk + src_word;
                                rdreq    <= !bus.SRC_EMPTY;
                                underrun <= underrun | bus.SRC_EMPTY;
                                word_cnt <= (state == DATA) ? word_cnt + 8'd1 : 8'h00;
                            end
                            CHKSUM: shreg <= chk;
                            default: begin
                                shreg    <= IDLE_WORD;
                                word_cnt <= 8'h00;
                            end
                        endcase
                    end
                end
            end
        end
    end

`ifdef OUT_SPI_FRAME_CNT_EN
    // Count accepted headers, wrapping at 255
    always_ff @(posedge RX_CLK or negedge RST) begin
        if (!RST)        FRAME_CNT <= 8'h00;
        else if (accept) FRAME_CNT <= FRAME_CNT + 8'd1;
    end
`endif

    assign tx_load           = (bit_cnt == 4'd0) && (state != IDLE) && (state != GAP);
    assign bus.TX_LOAD       = tx_load;
    assign bus.TX_STOP       = tx_load && (nxt_frame == GAP);
    assign bus.TX_DATA       = shreg[15];
    assign bus.MSG_ACK       = msg_ack;
    assign bus.SRC_RDREQ     = rdreq;
    assign bus.TX_BUSY       = busy;
    assign bus.UNDERRUN      = underrun;
    assign bus.state_monitor = state;

endmodule

// File: tb/tb_output_process_spi.sv
// tb_output_process_spi: frame-level checks of output_process_spi against a
// word-list model of the frame format, using a table of directed frames, a
// mid-frame reset sequence and randomized frames with random TX_EN gaps.
module tb_output_process_spi;
    localparam int   GAP_WORDS  = 1;
    localparam logic IDLE_LEVEL = 1'b0;

    logic RX_CLK = 1'b0;
    logic RST;

    output_process_spi_if bus();
`ifdef OUT_SPI_FRAME_CNT_EN
    logic [7:0] FRAME_CNT;
`endif

    output_process_spi dut (
        .RX_CLK (RX_CLK),
        .RST    (RST),
`ifdef OUT_SPI_FRAME_CNT_EN
        .FRAME_CNT (FRAME_CNT),
`endif
        .bus    (bus)
    );

    always #5 RX_CLK = ~RX_CLK;

    typedef struct {
        logic [15:0] code;
        logic [7:0]  len;
        int          nfifo;
        logic [15:0] d0;
        logic [15:0] d1;
        int          mode;
        int          exp_words;
        logic [15:0] exp_last;
        int          exp_rd;
        logic        exp_under;
    } vec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] fifo_q[$];
    logic [15:0] exp_w[$];
    logic        cap_bits[$];
    int          exp_rd;
    logic        exp_under;
    logic        exp_sticky;
    int          stop_cnt, stop_pos, load_bad, gap_cnt, gap_bad, rd_cnt, ack_cnt, hold_bad;
    logic        frame_done, dis_valid, dis_val;
    int          total_acks;
    vec_t        vt[7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] cap_word(input int k);
        logic [15:0] w;
        w = 16'h0000;
        for (int b = 0; b < 16; b++) w = {w[14:0], cap_bits[16*k+b]};
        return w;
    endfunction

    // One clock: drive TX_EN, observe at the falling edge, present FIFO head
    task automatic tick(input logic en);
        bus.TX_EN = en;
        @(negedge RX_CLK);
        if (bus.MSG_ACK) ack_cnt++;
        if (bus.SRC_RDREQ) begin
            rd_cnt++;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        if (bus.TX_BUSY) begin
            if (!bus.TX_EN) begin
                dis_valid = 1'b1;
                dis_val   = bus.TX_DATA;
            end else begin
                if (dis_valid && bus.TX_DATA !== dis_val) hold_bad++;
                dis_valid = 1'b0;
                if (!frame_done) begin
                    cap_bits.push_back(bus.TX_DATA);
                    if (bus.TX_LOAD !== (cap_bits.size() % 16 == 0)) load_bad++;
                    if (bus.TX_STOP) begin
                        stop_cnt++;
                        stop_pos   = cap_bits.size() - 1;
                        frame_done = 1'b1;
                    end
                end else begin
                    gap_cnt++;
                    if (bus.TX_DATA !== IDLE_LEVEL || bus.TX_LOAD || bus.TX_STOP) gap_bad++;
                end
            end
        end
        bus.SRC_EMPTY = (fifo_q.size() == 0);
        bus.SRC_DATA  = (fifo_q.size() == 0) ? 16'h0000 : fifo_q[0];
        @(posedge RX_CLK);
        #1;
    endtask

    task automatic clear_mon();
        cap_bits.delete();
        stop_cnt = 0; stop_pos = -1; load_bad = 0; gap_cnt = 0; gap_bad = 0;
        rd_cnt = 0; ack_cnt = 0; hold_bad = 0;
        frame_done = 1'b0; dis_valid = 1'b0; dis_val = 1'b0;
    endtask

    // Frame as a list of words, built from the format rules and the FIFO contents
    task automatic model(input logic [15:0] code, input logic [7:0] len);
        logic [15:0] sum, d;
        exp_w.delete();
        exp_rd = 0;
        exp_under = 1'b0;
        exp_w.push_back(16'h55AA);
        exp_w.push_back(code);
        if (code != 16'hFF00) begin
            sum = code;
            if (code[0]) begin
                exp_w.push_back({8'h00, len});
                sum = sum + {8'h00, len};
            end
            for (int i = 0; i < int'(len); i++) begin
                if (i < fifo_q.size()) begin
                    d = fifo_q[i];
                    exp_rd++;
                end else begin
                    d = 16'h0000;
                    exp_under = 1'b1;
                end
                exp_w.push_back(d);
                sum = sum + d;
            end
            if (code[1]) exp_w.push_back(sum);
        end
    endtask

    task automatic run_frame(input string tag, input logic [15:0] code, input logic [7:0] len,
                             input int mode);
        int   n;
        logic en;
        logic done;
        model(code, len);
        exp_sticky = exp_sticky | exp_under;
        clear_mon();
        bus.MSG_CODE  = code;
        bus.MSG_LEN   = len;
        bus.MSG_VALID = 1'b1;
        tick(1'b0);
        total_acks++;
        done = 1'b0;
        for (int c = 0; c < 20000; c++) begin
            if (c == 3) bus.MSG_VALID = 1'b0;
            case (mode)
                0:       en = 1'b1;
                1:       en = (c % 2 == 0);
                default: en = ($urandom_range(0, 3) != 0);
            endcase
            tick(en);
            if (!bus.TX_BUSY) begin
                done = 1'b1;
                break;
            end
        end
        bus.MSG_VALID = 1'b0;
        n = exp_w.size();
        chk({tag, "_finished"}, done, 1);
        chk({tag, "_bits"}, cap_bits.size(), 16 * n);
        for (int k = 0; k < n; k++)
            if (cap_bits.size() >= 16 * (k + 1))
                chk($sformatf("%s_word%0d", tag, k), cap_word(k), exp_w[k]);
        chk({tag, "_stop_cnt"}, stop_cnt, 1);
        chk({tag, "_stop_pos"}, stop_pos, 16 * n - 1);
        chk({tag, "_load_pos"}, load_bad, 0);
        chk({tag, "_gap_bits"}, gap_cnt, 16 * GAP_WORDS);
        chk({tag, "_gap_level"}, gap_bad, 0);
        chk({tag, "_rdreq"}, rd_cnt, exp_rd);
        chk({tag, "_ack"}, ack_cnt, 1);
        chk({tag, "_underrun"}, bus.UNDERRUN, exp_sticky);
        chk({tag, "_bit_hold"}, hold_bad, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ack"},    bus.MSG_ACK, 0);
        chk({tag, "_rdreq"},  bus.SRC_RDREQ, 0);
        chk({tag, "_load"},   bus.TX_LOAD, 0);
        chk({tag, "_stop"},   bus.TX_STOP, 0);
        chk({tag, "_busy"},   bus.TX_BUSY, 0);
        chk({tag, "_under"},  bus.UNDERRUN, 0);
        chk({tag, "_data"},   bus.TX_DATA, IDLE_LEVEL);
        chk({tag, "_state"},  bus.state_monitor, 0);
`ifdef OUT_SPI_FRAME_CNT_EN
        chk({tag, "_fcnt"},   FRAME_CNT, 0);
`endif
    endtask

    initial begin
        logic [15:0] code;
        logic [7:0]  len;
        int          nf;

        vt[0] = '{16'h0003, 8'd2,   2,   16'h1234, 16'h0001, 0, 6,   16'h123A, 2,   1'b0};
        vt[1] = '{16'hFF00, 8'd5,   1,   16'hBEEF, 16'h0000, 0, 2,   16'hFF00, 0,   1'b0};
        vt[2] = '{16'h0001, 8'd1,   1,   16'hABCD, 16'h0000, 1, 4,   16'hABCD, 1,   1'b0};
        vt[3] = '{16'h0001, 8'd0,   0,   16'h0000, 16'h0000, 0, 3,   16'h0000, 0,   1'b0};
        vt[4] = '{16'h0000, 8'd0,   1,   16'h5555, 16'h0000, 0, 2,   16'h0000, 0,   1'b0};
        vt[5] = '{16'h0002, 8'd255, 255, 16'h0100, 16'h0101, 2, 258, 16'h7D83, 255, 1'b0};
        vt[6] = '{16'h0140, 8'd2,   0,   16'h0000, 16'h0000, 0, 4,   16'h0000, 0,   1'b1};

        RST = 1'b0;
        bus.TX_EN = 1'b0;
        bus.MSG_VALID = 1'b0;
        bus.MSG_CODE = 16'h0000;
        bus.MSG_LEN = 8'h00;
        bus.SRC_DATA = 16'h0000;
        bus.SRC_EMPTY = 1'b1;
        exp_sticky = 1'b0;
        total_acks = 0;
        clear_mon();
        repeat (3) tick(1'b0);
        check_reset("reset");
        RST = 1'b1;
        tick(1'b0);

        // Directed frames
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < vt[i].nfifo; j++)
                fifo_q.push_back(j == 0 ? vt[i].d0 : vt[i].d1 + 16'(j - 1));
            run_frame($sformatf("v%0d", i), vt[i].code, vt[i].len, vt[i].mode);
            chk($sformatf("v%0d_tbl_words", i), cap_bits.size() / 16, vt[i].exp_words);
            if (cap_bits.size() >= 16)
                chk($sformatf("v%0d_tbl_last", i), cap_word(cap_bits.size() / 16 - 1), vt[i].exp_last);
            chk($sformatf("v%0d_tbl_rdreq", i), rd_cnt, vt[i].exp_rd);
            chk($sformatf("v%0d_tbl_under", i), bus.UNDERRUN, vt[i].exp_under);
            fifo_q.delete();
        end

        // Reset while bit 7 of the code word is on TX_DATA
        fifo_q.push_back(16'h1234);
        fifo_q.push_back(16'h0001);
        clear_mon();
        bus.MSG_CODE  = 16'h0003;
        bus.MSG_LEN   = 8'd2;
        bus.MSG_VALID = 1'b1;
        tick(1'b0);
        bus.MSG_VALID = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick(1'b1);
            if (cap_bits.size() == 24) break;
        end
        chk("midrst_reached", cap_bits.size(), 24);
        #2 RST = 1'b0;
        #1;
        check_reset("midrst");
        chk("midrst_no_pop", fifo_q.size(), 2);
        tick(1'b1);
        tick(1'b1);
        RST = 1'b1;
        exp_sticky = 1'b0;
        total_acks = 0;
        tick(1'b0);
        run_frame("fresh", 16'h0003, 8'd2, 0);
        fifo_q.delete();

        // Randomized back-to-back frames
        for (int r = 0; r < 12; r++) begin
            code = 16'($urandom) & 16'hF0F3;
            if ($urandom_range(0, 5) == 0) code = 16'hFF00;
            len = 8'($urandom_range(0, 6));
            nf = int'($urandom_range(0, int'(len)));
            for (int j = 0; j < nf; j++) fifo_q.push_back(16'($urandom));
            run_frame($sformatf("rnd%0d", r), code, len, int'($urandom_range(0, 1)) * 2);
            fifo_q.delete();
        end

`ifdef OUT_SPI_FRAME_CNT_EN
        chk("frame_cnt", FRAME_CNT, total_acks % 256);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/output_process_spi.md
Name: output_process_spi

Overview:
- Transmit-side counterpart of the SPI input message processor.
- Takes a message header (code, data length) and data words from the system side, builds a protocol frame and shifts it out MSB-first on the SPI clock:
  - prefix 16'h55AA
  - code word
  - optional length word
  - data words
  - optional checksum
- Data words come from a dual-clock FIFO in show-ahead mode, read side on RX_CLK.

Parameters:
- PREFIX, 16'h55AA, frame start word.
- EXIT_CODE, 16'hFF00, code sent as prefix+code only, with no length, data or checksum.
- IDLE_LEVEL, 1'b0, TX_DATA level outside frames.
- GAP_WORDS, 1, idle word slots (16 shift cycles each) inserted after every frame.

Ports:
- RST  in  1  asynchronous reset, active-low.
- RX_CLK  in  1  SPI bit clock; all logic on rising edge.
- TX_EN  in  1  shift enable; the frame advances one bit per edge with TX_EN=1.
- MSG_VALID  in  1  header valid.
- MSG_CODE  in  16  code word:
  - bit0 = length word present
  - bit1 = checksum present
- MSG_LEN  in  8  data word count.
- MSG_ACK  out  1  one-cycle header accept pulse.
- SRC_DATA  in  16  show-ahead FIFO head word.
- SRC_EMPTY  in  1  FIFO empty.
- SRC_RDREQ  out  1  FIFO pop, one cycle per data word.
- TX_DATA  out  1  serial data.
- TX_LOAD  out  1  high while the LSB of any word is on TX_DATA.
- TX_STOP  out  1  high while the LSB of the last frame word is on TX_DATA.
- TX_BUSY  out  1  high from accept until the gap ends.
- UNDERRUN  out  1  sticky; set when filler was sent because SRC_EMPTY=1.
- state_monitor  out  3  current state.

Behaviour:
- Reset values:
  - MSG_ACK, SRC_RDREQ, TX_LOAD, TX_STOP, TX_BUSY, UNDERRUN = 0.
  - TX_DATA = IDLE_LEVEL.
  - State IDLE; bit counter, word counter and checksum cleared.
- Reset is legal mid-frame: the frame is abandoned, nothing is resent, and already-popped words are lost.
- States: IDLE(0), PREFIX(1), CODE(2), LEN(3), DATA(4), CHKSUM(5), GAP(6).
- IDLE, accepting a header:
  - If MSG_VALID=1 at an edge, latch MSG_CODE/MSG_LEN, pulse MSG_ACK for one cycle and go to PREFIX.
  - TX_BUSY=1 and PREFIX bit15 appears on TX_DATA from that edge.
  - Accept is independent of TX_EN.
- Word shifting:
  - A 4-bit bit counter runs 15→0 and decrements only on edges with TX_EN=1.
  - TX_DATA holds a bit until an enabled edge.
  - When the counter is 0 and TX_EN=1, the next word loads.
- Word sequence after PREFIX:
  - CODE.
  - LEN {8'h00, MSG_LEN} if code bit0=1.
  - DATA, MSG_LEN words; skipped if MSG_LEN=0.
  - CHKSUM if code bit1=1.
  - GAP.
- EXIT_CODE: goes CODE→GAP regardless of code bits.
- Checksum: 16-bit wrap-around sum of the code word, the length word (if sent) and every data word actually sent (filler included). The prefix is excluded.
- DATA word loading:
  - On loading a data word, the shift register takes SRC_DATA and SRC_RDREQ=1 for that single cycle.
  - If SRC_EMPTY=1 at load: shift 16'h0000, no SRC_RDREQ, set UNDERRUN. Word count still advances so frame length is preserved.
- Word count: an 8-bit counter compared with MSG_LEN-1; MSG_LEN=255 sends 255 words.
- TX_LOAD/TX_STOP: combinational from the bit counter and current state; TX_STOP on LSB of CODE (exit), CHKSUM, last DATA, or LEN when MSG_LEN=0 and no checksum.
- GAP: TX_DATA=IDLE_LEVEL for GAP_WORDS×16 enabled edges, then IDLE with TX_BUSY=0. The next header is accepted no earlier than the edge after reaching IDLE.
- MSG_VALID held high while busy is ignored; the header is only accepted in IDLE.
- UNDERRUN clears only on reset.

Optional Feature:
- Macro: OUT_SPI_FRAME_CNT_EN.
- Defined: adds output FRAME_CNT[7:0], reset 0, incrementing on every MSG_ACK and wrapping 255→0.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Code 16'h0003, len 2, FIFO {16'h1234, 16'h0001}, TX_EN=1 → serial words 55AA, 0003, 0002, 1234, 0001, chksum 123A:
  - TX_STOP with the chksum LSB
  - 2 SRC_RDREQ pulses
  - 96 bit-cycles, then 16 idle.
- Code 16'hFF00 → only 55AA, FF00 sent; TX_STOP on the FF00 LSB; no SRC_RDREQ.
- Code 16'h0140, len 2, FIFO empty → 55AA, 0140, 0000, 0000; UNDERRUN=1; no SRC_RDREQ.
- Code 16'h0001, len 1, TX_EN toggling 1-0 → same bit sequence as continuous TX_EN, each bit held two cycles.
- Reset asserted at bit 7 of the CODE word → all outputs return to reset values immediately; the next header then sends a complete fresh frame.
- With OUT_SPI_FRAME_CNT_EN: three back-to-back headers → FRAME_CNT=3.
